// File: rtl/clock_pkg.sv
// ---------------------------------------------------------------------------
// clock_pkg
// Shared definitions for the digital clock time-setting logic.
//   state_t : controller states (RUN, SET_HR, SET_MIN, COMMIT)
//   HR_W    : width of the hour field
//   MIN_W   : width of the minute field
//   MIN_MAX : highest minute value (field wraps MIN_MAX -> 0)
// ---------------------------------------------------------------------------
package clock_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2,
        COMMIT  = 2'd3
    } state_t;

    localparam int HR_W    = 5;
    localparam int MIN_W   = 6;
    localparam int MIN_MAX = 59;

endpackage

// File: rtl/field_wrap_inc.sv
// ---------------------------------------------------------------------------
// field_wrap_inc
// Combinational wrap-around incrementer for one time field.
//   i_value [W-1:0] : current field value (assumed <= MAX)
//   i_en            : 1 = increment, 0 = pass value through
//   o_next  [W-1:0] : next value; MAX wraps to 0 (compare, never modulo)
// ---------------------------------------------------------------------------
module field_wrap_inc #(
    parameter int W   = 6,
    parameter int MAX = 59
) (
    input  logic [W-1:0] i_value,
    input  logic         i_en,
    output logic [W-1:0] o_next
);

    logic w_at_max;

    assign w_at_max = (i_value == W'(MAX));

    always_comb begin
        o_next = i_value;
        if (i_en) begin
            o_next = w_at_max ? '0 : i_value + 1'b1;
        end
    end

endmodule

// File: rtl/clock_set_ctrl.sv
// ---------------------------------------------------------------------------
// clock_set_ctrl
// Time-setting controller: selects live/edit display source, edits hours
// then minutes via debounced buttons, and commits with a one-cycle load.
//
// Parameters:
//   TIMEOUT_S : idle 1 Hz ticks before an edit is abandoned (0 = never)
//   HR_MAX    : highest hour value (hour field wraps HR_MAX -> 0)
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   tick_1hz              : one-cycle pulse per second
//   btn_mode, btn_inc     : debounced one-cycle button pulses
//   live_hr, live_min     : current timekeeper time
//   sel                   : display mux select (0 live, 1 edit register)
//   edit_hr, edit_min     : edit register
//   load                  : one-cycle commit pulse to the timekeeper
//   blank_hr, blank_min   : digit blanking for blink
// Build option:
//   CLOCK_SET_BLINK_EN    : when defined, the field being edited blinks at
//                           the tick rate; otherwise blank_* are tied to 0.
// ---------------------------------------------------------------------------
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int TIMEOUT_S = 10,
    parameter int HR_MAX    = 23
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick_1hz,
    input  logic             btn_mode,
    input  logic             btn_inc,
    input  logic [HR_W-1:0]  live_hr,
    input  logic [MIN_W-1:0] live_min,
    output logic             sel,
    output logic [HR_W-1:0]  edit_hr,
    output logic [MIN_W-1:0] edit_min,
    output logic             load,
    output logic             blank_hr,
    output logic             blank_min
);

    state_t             r_state;
    state_t             w_state_next;
    logic               r_sel;
    logic               r_load;
    logic [HR_W-1:0]    r_edit_hr;
    logic [MIN_W-1:0]   r_edit_min;
    logic [HR_W-1:0]    w_hr_next;
    logic [MIN_W-1:0]   w_min_next;
    logic               w_any_btn;
    logic               w_editing;
    logic               w_idle_tick;
    logic               w_timeout;
    logic               w_inc_hr;
    logic               w_inc_min;

    assign w_any_btn   = btn_mode | btn_inc;
    assign w_editing   = (r_state == SET_HR) || (r_state == SET_MIN);
    // A tick only counts as idle time when no button arrives with it.
    assign w_idle_tick = w_editing && tick_1hz && !w_any_btn;
    // btn_mode has priority: a simultaneous increment is discarded.
    assign w_inc_hr    = (r_state == SET_HR)  && btn_inc && !btn_mode;
    assign w_inc_min   = (r_state == SET_MIN) && btn_inc && !btn_mode;

    field_wrap_inc #(.W(HR_W), .MAX(HR_MAX)) u_hr_inc (
        .i_value (r_edit_hr),
        .i_en    (w_inc_hr),
        .o_next  (w_hr_next)
    );

    field_wrap_inc #(.W(MIN_W), .MAX(MIN_MAX)) u_min_inc (
        .i_value (r_edit_min),
        .i_en    (w_inc_min),
        .o_next  (w_min_next)
    );

    // -----------------------------------------------------------------------
    // Idle timeout counter
    // -----------------------------------------------------------------------
    generate
        if (TIMEOUT_S > 0) begin : g_timeout
            localparam int IDLE_W = (TIMEOUT_S < 2) ? 1 : $clog2(TIMEOUT_S + 1);
            logic [IDLE_W-1:0] r_idle;

            // Fires on the tick that would bring the count to TIMEOUT_S.
            assign w_timeout = w_idle_tick && (r_idle == IDLE_W'(TIMEOUT_S - 1));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_idle <= '0;
                end else if (w_any_btn || w_timeout) begin
                    // Entry to SET_HR is always via btn_mode, so this also
                    // clears the counter on entry.
                    r_idle <= '0;
                end else if (w_idle_tick) begin
                    r_idle <= r_idle + 1'b1;
                end
            end
        end else begin : g_no_timeout
            assign w_timeout = 1'b0;
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            RUN: begin
                if (btn_mode) w_state_next = SET_HR;
            end
            SET_HR: begin
                if (btn_mode)       w_state_next = SET_MIN;
                else if (w_timeout) w_state_next = RUN;
            end
            SET_MIN: begin
                if (btn_mode)       w_state_next = COMMIT;
                else if (w_timeout) w_state_next = RUN;
            end
            COMMIT: begin
                w_state_next = RUN;
            end
            default: begin
                w_state_next = RUN;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State, registered outputs and edit register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= RUN;
            r_sel      <= 1'b0;
            r_load     <= 1'b0;
            r_edit_hr  <= '0;
            r_edit_min <= '0;
        end else begin
            r_state <= w_state_next;
            // Outputs are derived from the next state so they line up with
            // the state they describe.
            r_sel   <= (w_state_next != RUN);
            r_load  <= (w_state_next == COMMIT);
            if ((r_state == RUN) && btn_mode) begin
                r_edit_hr  <= live_hr;
                r_edit_min <= live_min;
            end else begin
                r_edit_hr  <= w_hr_next;
                r_edit_min <= w_min_next;
            end
        end
    end

    assign sel      = r_sel;
    assign load     = r_load;
    assign edit_hr  = r_edit_hr;
    assign edit_min = r_edit_min;

    // -----------------------------------------------------------------------
    // Blink
    // -----------------------------------------------------------------------
`ifdef CLOCK_SET_BLINK_EN
    logic r_phase;
    logic w_phase_next;
    logic r_blank_hr;
    logic r_blank_min;

    always_comb begin
        w_phase_next = r_phase;
        if (w_any_btn) begin
            // Field becomes visible immediately on any button activity.
            w_phase_next = 1'b0;
        end else if (w_idle_tick) begin
            w_phase_next = ~r_phase;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase     <= 1'b0;
            r_blank_hr  <= 1'b0;
            r_blank_min <= 1'b0;
        end else begin
            r_phase     <= w_phase_next;
            r_blank_hr  <= (w_state_next == SET_HR)  && w_phase_next;
            r_blank_min <= (w_state_next == SET_MIN) && w_phase_next;
        end
    end

    assign blank_hr  = r_blank_hr;
    assign blank_min = r_blank_min;
`else
    assign blank_hr  = 1'b0;
    assign blank_min = 1'b0;
`endif

endmodule

// File: doc/clock_set_ctrl.md
# clock_set_ctrl

Time-setting controller for the digital clock. It sequences the 2:1 display multiplexer between the live timekeeper value and an edit register. It runs a mode-button state machine that edits hours and then minutes, and it commits the edited time to the timekeeper with a one-cycle load pulse. It sits between the debounced button pulses and the display MUX select / timekeeper load inputs.

## Interface
- TIMEOUT_S, 10: 1 Hz ticks with no button activity before an edit is abandoned; 0 disables the timeout.
- HR_MAX, 23: highest hour value; the hour field wraps HR_MAX→0.
- clk  input  1  system clock
- rst_n  input  1  asynchronous, active-low reset
- tick_1hz  input  1  single-cycle pulse once per second
- btn_mode  input  1  debounced single-cycle pulse: enter / advance / commit
- btn_inc  input  1  debounced single-cycle pulse: increment the active field
- live_hr  input  5  current timekeeper hours
- live_min  input  6  current timekeeper minutes
- sel  output  1  display MUX select: 0 = live time, 1 = edit register
- edit_hr  output  5  edit register, hours
- edit_min  output  6  edit register, minutes
- load  output  1  one-cycle pulse: timekeeper captures edit_hr/edit_min
- blank_hr  output  1  blank the hour digits (blink)
- blank_min  output  1  blank the minute digits (blink)

## Operation
- States: RUN, SET_HR, SET_MIN, COMMIT. Reset state is RUN.
- RUN:
  - btn_mode → SET_HR; edit_hr/edit_min capture live_hr/live_min in the same edge.
  - btn_inc is ignored.
- SET_HR:
  - btn_inc: edit_hr = (edit_hr==HR_MAX) ? 0 : edit_hr+1.
  - btn_mode → SET_MIN.
- SET_MIN:
  - btn_inc: edit_min = (edit_min==59) ? 0 : edit_min+1.
  - btn_mode → COMMIT.
- COMMIT: load=1 for exactly this cycle, then unconditionally → RUN. Buttons are ignored in COMMIT.
- sel = 1 in SET_HR, SET_MIN and COMMIT; sel = 0 in RUN.
- Simultaneous btn_mode and btn_inc: btn_mode wins and the increment is discarded.
- Timeout (TIMEOUT_S>0):
  - An idle counter clears on entry to SET_HR and on any button pulse.
  - The counter increments on tick_1hz in SET_HR/SET_MIN.
  - When it reaches TIMEOUT_S, the block returns to RUN with no load pulse. Edit values are retained but not displayed.
- Edit registers hold their value in RUN; they are reloaded only on entry to SET_HR.
- Arithmetic: all increments are wrap-compare, never modulo; no value above HR_MAX or 59 is ever produced. live_hr/live_min are assumed legal by the timekeeper contract.

## Timing
- Reset values: state RUN, sel 0, edit_hr 0, edit_min 0, load 0, blank_hr 0, blank_min 0, idle counter 0, blink phase 0.
- All outputs are registered; no combinational path from input to output.
- btn_mode in RUN at edge N: from N+1, sel=1 and edit_* = live_* sampled at edge N.
- btn_inc at edge N: the new edit value is visible from N+1.
- btn_mode in SET_MIN at edge N: load=1 during cycle N+1 and sel=1. At N+2, load=0 and sel=0, and the display shows the timekeeper, which must have captured at the end of N+1.
- Asserting rst_n low mid-edit forces RUN immediately and asynchronously. No load is issued and the edit is lost.
- tick_1hz coincident with a button pulse: the button clears the idle counter and the tick does not count.

## Configuration
- CLOCK_SET_BLINK_EN defined:
  - A blink phase bit toggles on tick_1hz in SET_HR/SET_MIN.
  - The phase bit is forced to 0 (visible) on entry to SET_HR and on every button pulse.
  - blank_hr = phase in SET_HR; blank_min = phase in SET_MIN; both are 0 otherwise.
- CLOCK_SET_BLINK_EN undefined: blank_hr and blank_min are constant 0 and the phase register is absent.

## Structure
- Shared package clock_pkg holds:
  - the state enum: RUN, SET_HR, SET_MIN, COMMIT;
  - width constants: HR_W=5, MIN_W=6;
  - MIN_MAX=59.
- One sub-module, field_wrap_inc, parameterised by width and max value. It takes a value and an enable, and returns the next wrapped value. It is instantiated once for hours and once for minutes.

## Test plan
- Reset with rst_n=0 and random inputs → all outputs 0, state RUN. Release → btn_inc pulses leave edit_* and sel unchanged.
- live=13:45, btn_mode → sel=1, edit=13:45. 12×btn_inc → edit_hr=1 (wrap after 23). btn_mode, 15×btn_inc → edit_min=0 (wrap after 59). btn_mode → one-cycle load with edit=01:00, then sel=0.
- btn_mode and btn_inc in the same cycle in SET_HR → state SET_MIN and edit_hr unchanged.
- In SET_MIN, 10 tick_1hz with no buttons (TIMEOUT_S=10) → RUN, sel=0, load never asserted. Same case with a btn_inc at tick 9 → still in SET_MIN after tick 10.
- rst_n pulsed low while in SET_MIN → immediate RUN, sel=0, no load. The next btn_mode reloads edit_* from live.
- With CLOCK_SET_BLINK_EN, in SET_HR, 3 ticks → blank_hr sequence 1,0,1 and blank_min=0. A btn_inc → blank_hr=0 next cycle. Without the macro, blank_* stay 0 throughout.
